noc_bridge_vc_scheduler: RTL and testbench

Transmit-side scheduler for the virtual-channel NoC bridge. It arbitrates narrow request and response flits onto the single AXIS link and enforces per-channel credit-based flow control toward the remote bridge. It also piggybacks credit returns for the local receive buffers onto every outgoing packet. It sits between the floo narrow channels and the AXIS packet register that feeds the serial link.

---
 rtl/noc_bridge_vc_scheduler.sv | 117 +++++++++++
 tb/tb_noc_bridge_vc_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/noc_bridge_vc_scheduler.sv
// noc_bridge_vc_scheduler: arbitrates request/response flits onto the AXIS link with
// per-channel transmit credits and piggybacked return credits for the local RX FIFOs.
module noc_bridge_vc_scheduler #(
    parameter int unsigned NumCred   = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CredWidth = $clog2(NumCred + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [DataWidth-1:0] rsp_data_i,
    input  logic                 rx_pop_req_i,
    input  logic                 rx_pop_rsp_i,
    input  logic                 rx_cred_valid_i,
    input  logic                 rx_cred_hdr_i,
    input  logic [CredWidth-1:0] rx_cred_i,
    output logic                 axis_valid_o,
    input  logic                 axis_ready_i,
    output logic                 tx_data_hdr_o,
    output logic [DataWidth-1:0] tx_data_o,
    output logic                 tx_data_validity_o,
    output logic                 tx_credits_hdr_o,
    output logic [CredWidth-1:0] tx_credits_o,
    output logic [CredWidth-1:0] cred_req_o,
    output logic [CredWidth-1:0] cred_rsp_o
);
    localparam logic [CredWidth-1:0] MaxCred = CredWidth'(NumCred);
    localparam logic [CredWidth:0]   MaxSum  = (CredWidth + 1)'(NumCred);

    logic                 valid_q, valid_d;
    logic                 data_hdr_q, data_hdr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 validity_q, validity_d;
    logic                 cred_hdr_q, cred_hdr_d;
    logic [CredWidth-1:0] credits_q, credits_d;
    logic [CredWidth-1:0] cred_req_q, cred_req_d, cred_rsp_q, cred_rsp_d;
    logic [CredWidth-1:0] ret_req_q, ret_req_d, ret_rsp_q, ret_rsp_d;
    logic                 rr_req_q, rr_req_d;
    logic                 slot_free, elig_req, elig_rsp, gnt_req, gnt_rsp, load, sel_req;
    logic [CredWidth:0]   sum_req, sum_rsp;

    assign slot_free = !valid_q || axis_ready_i;
    // Eligibility uses only registered credits, so same-cycle returns never unblock a stalled channel
    assign elig_req  = req_valid_i && (cred_req_q != '0);
    assign elig_rsp  = rsp_valid_i && (cred_rsp_q != '0);
    assign gnt_req   = rst_ni && slot_free && elig_req && (!elig_rsp || rr_req_q);
    assign gnt_rsp   = rst_ni && slot_free && elig_rsp && (!elig_req || !rr_req_q);
    assign sel_req   = ret_req_q >= ret_rsp_q;
    assign load      = gnt_req || gnt_rsp || (slot_free && (ret_req_q != '0 || ret_rsp_q != '0));

    assign sum_req = {1'b0, cred_req_q} + ((rx_cred_valid_i && rx_cred_hdr_i) ? {1'b0, rx_cred_i} : '0)
                   - (CredWidth + 1)'(gnt_req);
    assign sum_rsp = {1'b0, cred_rsp_q} + ((rx_cred_valid_i && !rx_cred_hdr_i) ? {1'b0, rx_cred_i} : '0)
                   - (CredWidth + 1)'(gnt_rsp);

    always_comb begin
        valid_d    = load || (valid_q && !axis_ready_i);
        data_hdr_d = load ? gnt_req : data_hdr_q;
        data_d     = load ? (gnt_req ? req_data_i : gnt_rsp ? rsp_data_i : '0) : data_q;
        validity_d = load ? (gnt_req || gnt_rsp) : validity_q;
        cred_hdr_d = load ? sel_req : cred_hdr_q;
        credits_d  = load ? (sel_req ? ret_req_q : ret_rsp_q) : credits_q;
        cred_req_d = (sum_req > MaxSum) ? MaxCred : sum_req[CredWidth-1:0];
        cred_rsp_d = (sum_rsp > MaxSum) ? MaxCred : sum_rsp[CredWidth-1:0];
        ret_req_d  = (load && sel_req) ? CredWidth'(rx_pop_req_i)
                   : ret_req_q + CredWidth'(rx_pop_req_i && ret_req_q != MaxCred);
        ret_rsp_d  = (load && !sel_req) ? CredWidth'(rx_pop_rsp_i)
                   : ret_rsp_q + CredWidth'(rx_pop_rsp_i && ret_rsp_q != MaxCred);
        rr_req_d   = gnt_req ? 1'b0 : gnt_rsp ? 1'b1 : rr_req_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            data_hdr_q <= 1'b0;
            data_q     <= '0;
            validity_q <= 1'b0;
            cred_hdr_q <= 1'b0;
            credits_q  <= '0;
            cred_req_q <= MaxCred;
            cred_rsp_q <= MaxCred;
            ret_req_q  <= '0;
            ret_rsp_q  <= '0;
            rr_req_q   <= 1'b1;
        end else begin
            valid_q    <= valid_d;
            data_hdr_q <= data_hdr_d;
            data_q     <= data_d;
            validity_q <= validity_d;
            cred_hdr_q <= cred_hdr_d;
            credits_q  <= credits_d;
            cred_req_q <= cred_req_d;
            cred_rsp_q <= cred_rsp_d;
            ret_req_q  <= ret_req_d;
            ret_rsp_q  <= ret_rsp_d;
            rr_req_q   <= rr_req_d;
        end
    end

    a_req_cred_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) sum_req <= MaxSum);
    a_rsp_cred_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) sum_rsp <= MaxSum);

    assign req_ready_o        = gnt_req;
    assign rsp_ready_o        = gnt_rsp;
    assign axis_valid_o       = valid_q;
    assign tx_data_hdr_o      = data_hdr_q;
    assign tx_data_o          = data_q;
    assign tx_data_validity_o = validity_q;
    assign tx_credits_hdr_o   = cred_hdr_q;
    assign tx_credits_o       = credits_q;
    assign cred_req_o         = cred_req_q;
    assign cred_rsp_o         = cred_rsp_q;
endmodule

// File: tb/tb_noc_bridge_vc_scheduler.sv
// tb_noc_bridge_vc_scheduler: directed vector table plus a mid-burst reset sequence.
module tb_noc_bridge_vc_scheduler;
    localparam int CW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0] req_data, rsp_data;
    logic          pop_req, pop_rsp, cred_valid, cred_hdr;
    logic [CW-1:0] cred_n;
    logic          axis_valid, axis_ready;
    logic          tx_hdr, tx_validity, tx_cred_hdr;
    logic [DW-1:0] tx_data;
    logic [CW-1:0] tx_credits, cred_req, cred_rsp;

    noc_bridge_vc_scheduler #(.NumCred(8), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_data_i(rsp_data),
        .rx_pop_req_i(pop_req), .rx_pop_rsp_i(pop_rsp),
        .rx_cred_valid_i(cred_valid), .rx_cred_hdr_i(cred_hdr), .rx_cred_i(cred_n),
        .axis_valid_o(axis_valid), .axis_ready_i(axis_ready),
        .tx_data_hdr_o(tx_hdr), .tx_data_o(tx_data), .tx_data_validity_o(tx_validity),
        .tx_credits_hdr_o(tx_cred_hdr), .tx_credits_o(tx_credits),
        .cred_req_o(cred_req), .cred_rsp_o(cred_rsp)
    );

    always #5 clk = ~clk;

    // in = {req_v, rsp_v, axis_ready, pop_req, pop_rsp}; cr = {cred_valid, cred_hdr, cred_n}
    // ex = {req_ready, rsp_ready, axis_valid, data_hdr, validity, credits_hdr}
    typedef struct {
        logic [4:0]    in;
        logic [5:0]    cr;
        logic [5:0]    ex;
        logic [CW-1:0] ecn;
        logic [DW-1:0] data;
        logic [CW-1:0] ecr;
        logic [CW-1:0] ecs;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic [4:0] in, input logic [5:0] cr, input logic [5:0] ex,
                                input logic [CW-1:0] ecn, input logic [DW-1:0] data,
                                input logic [CW-1:0] ecr, input logic [CW-1:0] ecs);
        vec_t v;
        v.in = in; v.cr = cr; v.ex = ex; v.ecn = ecn; v.data = data; v.ecr = ecr; v.ecs = ecs;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // 8-flit request burst, then the 9th stalls
        for (int i = 0; i < 8; i++) add(5'b10100, 6'd0, 6'b101111, 4'd0, 16'hA000 + 16'(i), 4'(7 - i), 4'd8);
        add(5'b10100, 6'd0, 6'b000001, 4'd0, 16'h0, 4'd0, 4'd8);
        // credit arrives while req waits: no grant this cycle, 3 flits afterwards
        add(5'b10100, 6'b110011, 6'b000001, 4'd0, 16'h0, 4'd3, 4'd8);
        for (int i = 10; i < 13; i++) add(5'b10100, 6'd0, 6'b101111, 4'd0, 16'hA000 + 16'(i), 4'(12 - i), 4'd8);
        add(5'b10100, 6'd0, 6'b000001, 4'd0, 16'h0, 4'd0, 4'd8);
        // refill request credits while one response flit flips the pointer
        add(5'b01100, 6'b111000, 6'b011011, 4'd0, 16'hB000 + 16'd14, 4'd8, 4'd7);
        // fairness: both valid -> req, rsp, req, rsp
        add(5'b11100, 6'd0, 6'b101111, 4'd0, 16'hA000 + 16'd15, 4'd7, 4'd7);
        add(5'b11100, 6'd0, 6'b011011, 4'd0, 16'hB000 + 16'd16, 4'd7, 4'd6);
        add(5'b11100, 6'd0, 6'b101111, 4'd0, 16'hA000 + 16'd17, 4'd6, 4'd6);
        add(5'b11100, 6'd0, 6'b011011, 4'd0, 16'hB000 + 16'd18, 4'd6, 4'd5);
        // backpressure 5 cycles: outputs hold, no ready, two rsp pops accumulate
        for (int i = 19; i < 22; i++) add(5'b11000, 6'd0, 6'b001011, 4'd0, 16'hB000 + 16'd18, 4'd6, 4'd5);
        for (int i = 22; i < 24; i++) add(5'b11001, 6'd0, 6'b001011, 4'd0, 16'hB000 + 16'd18, 4'd6, 4'd5);
        // credit-only packet with a simultaneous pop, then the leftover credit
        add(5'b00101, 6'd0, 6'b001000, 4'd2, 16'h0, 4'd6, 4'd5);
        add(5'b00100, 6'd0, 6'b001000, 4'd1, 16'h0, 4'd6, 4'd5);
        add(5'b00100, 6'd0, 6'b000001, 4'd0, 16'h0, 4'd6, 4'd5);
        // build ret 2/2, then a data packet takes the tie (request) and the rsp credits follow
        add(5'b10111, 6'd0, 6'b101111, 4'd0, 16'hA000 + 16'd27, 4'd5, 4'd5);
        add(5'b00011, 6'd0, 6'b001111, 4'd0, 16'hA000 + 16'd27, 4'd5, 4'd5);
        add(5'b01100, 6'd0, 6'b011011, 4'd2, 16'hB000 + 16'd29, 4'd5, 4'd4);
        add(5'b00100, 6'd0, 6'b001000, 4'd2, 16'h0, 4'd5, 4'd4);
        add(5'b00100, 6'd0, 6'b000001, 4'd0, 16'h0, 4'd5, 4'd4);

        rst_n = 1'b0;
        {req_valid, rsp_valid, axis_ready, pop_req, pop_rsp, cred_valid, cred_hdr} = '0;
        cred_n = '0; req_data = '0; rsp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        axis_ready = 1'b1;
        #1;
        chk("reset axis_valid", axis_valid, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset tx_credits", tx_credits, 0);
        chk("reset tx_hdrs", {tx_hdr, tx_validity, tx_cred_hdr}, 0);
        chk("reset cred_req", cred_req, 8);
        chk("reset cred_rsp", cred_rsp, 8);
        rst_n = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            {req_valid, rsp_valid, axis_ready, pop_req, pop_rsp} = tbl[r].in;
            {cred_valid, cred_hdr, cred_n} = tbl[r].cr;
            req_data = 16'hA000 + 16'(r);
            rsp_data = 16'hB000 + 16'(r);
            #1;
            chk($sformatf("r%0d req_ready", r), req_ready, tbl[r].ex[5]);
            chk($sformatf("r%0d rsp_ready", r), rsp_ready, tbl[r].ex[4]);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d axis_valid", r), axis_valid, tbl[r].ex[3]);
            if (tbl[r].ex[3]) begin
                chk($sformatf("r%0d data_hdr", r), tx_hdr, tbl[r].ex[2]);
                chk($sformatf("r%0d validity", r), tx_validity, tbl[r].ex[1]);
                chk($sformatf("r%0d credits_hdr", r), tx_cred_hdr, tbl[r].ex[0]);
                chk($sformatf("r%0d credits", r), tx_credits, tbl[r].ecn);
                chk($sformatf("r%0d data", r), tx_data, tbl[r].data);
            end
            chk($sformatf("r%0d cred_req", r), cred_req, tbl[r].ecr);
            chk($sformatf("r%0d cred_rsp", r), cred_rsp, tbl[r].ecs);
            @(negedge clk);
        end

        // mid-burst asynchronous reset
        {req_valid, rsp_valid, axis_ready, pop_req, pop_rsp, cred_valid, cred_hdr} = 7'b1010000;
        req_data = 16'h5A5A;
        @(posedge clk);
        #1;
        chk("burst axis_valid", axis_valid, 1);
        chk("burst cred_req", cred_req, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst axis_valid", axis_valid, 0);
        chk("midrst req_ready", req_ready, 0);
        chk("midrst tx_data", tx_data, 0);
        chk("midrst cred_req", cred_req, 8);
        chk("midrst cred_rsp", cred_rsp, 8);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release req_ready", req_ready, 1);
        chk("release cred_req", cred_req, 8);
        @(posedge clk);
        #1;
        chk("release axis_valid", axis_valid, 1);
        chk("release data_hdr", tx_hdr, 1);
        chk("release data", tx_data, 16'h5A5A);
        chk("release cred_req after flit", cred_req, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
